// File: rtl/mem_stream_writer_if.sv
// -----------------------------------------------------------------------------
// mem_stream_writer_if
// Bundles the two buses of the stream writer: the incoming word stream
// (valid/ready handshake) and the single-port RAM pins it drives.
//
// Signals:
//   in_data   stream word
//   in_valid  in_data valid
//   in_ready  writer accepts a word this cycle
//   address   RAM address
//   data      RAM write data
//   wren      RAM write enable
//   q         RAM read data (registered RAM output)
//
// Modports:
//   master  environment side: stream source plus RAM (drives in_data, in_valid, q)
//   slave   writer side (drives in_ready, address, data, wren)
// -----------------------------------------------------------------------------
interface mem_stream_writer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 7
) ();
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] data;
   logic                  wren;
   logic [DATA_WIDTH-1:0] q;

   modport master (
      output in_data, in_valid, q,
      input  in_ready, address, data, wren
   );

   modport slave (
      input  in_data, in_valid, q,
      output in_ready, address, data, wren
   );
endinterface

// File: rtl/mem_stream_writer.sv
// -----------------------------------------------------------------------------
// mem_stream_writer
// Accepts a word stream over a valid/ready handshake and writes it into
// consecutive RAM addresses (modulo 2^ADDR_WIDTH) starting at a programmable
// base. All outputs are registered; a handshake at one edge produces the RAM
// write (address/data/wren) in the following cycle.
//
// Optional feature, enabled by defining MEM_WRITER_READBACK_EN:
//   after the write pass, every written address is read back, the read words
//   are XOR-folded and compared with the XOR of the written words; a
//   difference raises `mismatch`. Without the macro `q` is unused and
//   `mismatch` is tied low.
//
// Ports:
//   clock      sole clock, rising edge
//   reset      asynchronous, active-high
//   start      single-cycle transfer request, honoured only when idle
//   base_addr  first RAM address, captured with start
//   num_words  number of words (0..2^ADDR_WIDTH, larger values clamp)
//   bus        stream + RAM interface (slave modport)
//   busy       transfer in progress
//   done       one-cycle pulse at end of transfer
//   mismatch   read-back check failed; held until the next accepted start
// -----------------------------------------------------------------------------
module mem_stream_writer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   num_words,
   mem_stream_writer_if.slave    bus,
   output logic                  busy,
   output logic                  done,
   output logic                  mismatch
);

   localparam logic [ADDR_WIDTH:0] DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] ZERO_CNT = {(ADDR_WIDTH+1){1'b0}};

`ifdef MEM_WRITER_READBACK_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      VERIFY = 2'd2,
      DONE   = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      DONE   = 2'd3
   } state_t;
`endif

   // A request larger than the RAM depth is limited to one full pass.
   function automatic logic [ADDR_WIDTH:0] clamp_count(input logic [ADDR_WIDTH:0] n);
      return (n > DEPTH) ? DEPTH : n;
   endfunction

   state_t                state;
   logic [ADDR_WIDTH-1:0] base;
   logic [ADDR_WIDTH:0]   count;
   logic [ADDR_WIDTH:0]   offset;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [DATA_WIDTH-1:0] data_reg;
   logic                  wren_reg;
   logic                  ready_reg;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] next_addr;

   // Handshake and wrapping address for the current offset.
   assign accept    = bus.in_valid && ready_reg;
   assign next_addr = base + offset[ADDR_WIDTH-1:0];

   assign bus.in_ready = ready_reg;
   assign bus.address  = addr_reg;
   assign bus.data     = data_reg;
   assign bus.wren     = wren_reg;

`ifdef MEM_WRITER_READBACK_EN
   logic [DATA_WIDTH-1:0] wr_sum;
   logic [DATA_WIDTH-1:0] rd_sum;
   logic [1:0]            rd_pipe;   // tracks read addresses still in the RAM pipeline
   logic                  issue;

   assign issue = (offset != count);
`else
   logic unused_q;

   assign unused_q = ^bus.q;
   assign mismatch = 1'b0;
`endif

   // Transfer state machine; every output is registered here.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         base      <= {ADDR_WIDTH{1'b0}};
         count     <= ZERO_CNT;
         offset    <= ZERO_CNT;
         addr_reg  <= {ADDR_WIDTH{1'b0}};
         data_reg  <= {DATA_WIDTH{1'b0}};
         wren_reg  <= 1'b0;
         ready_reg <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef MEM_WRITER_READBACK_EN
         wr_sum    <= {DATA_WIDTH{1'b0}};
         rd_sum    <= {DATA_WIDTH{1'b0}};
         rd_pipe   <= 2'b00;
         mismatch  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done     <= 1'b0;
               wren_reg <= 1'b0;
               if (start) begin
                  base   <= base_addr;
                  count  <= clamp_count(num_words);
                  offset <= ZERO_CNT;
                  busy   <= 1'b1;
`ifdef MEM_WRITER_READBACK_EN
                  wr_sum   <= {DATA_WIDTH{1'b0}};
                  mismatch <= 1'b0;
`endif
                  if (num_words == ZERO_CNT) begin
                     ready_reg <= 1'b0;
                     state     <= DONE;
                  end else begin
                     ready_reg <= 1'b1;
                     state     <= WRITE;
                  end
               end else begin
                  busy      <= 1'b0;
                  ready_reg <= 1'b0;
               end
            end

            WRITE: begin
               done <= 1'b0;
               busy <= 1'b1;
               if (accept) begin
                  wren_reg <= 1'b1;
                  addr_reg <= next_addr;
                  data_reg <= bus.in_data;
`ifdef MEM_WRITER_READBACK_EN
                  wr_sum   <= wr_sum ^ bus.in_data;
`endif
                  if (offset + ONE == count) begin
                     // Last word: stop accepting right away, reuse offset for read-back.
                     ready_reg <= 1'b0;
                     offset    <= ZERO_CNT;
`ifdef MEM_WRITER_READBACK_EN
                     rd_sum    <= {DATA_WIDTH{1'b0}};
                     rd_pipe   <= 2'b00;
                     state     <= VERIFY;
`else
                     state     <= DONE;
`endif
                  end else begin
                     ready_reg <= 1'b1;
                     offset    <= offset + ONE;
                  end
               end else begin
                  wren_reg  <= 1'b0;
                  ready_reg <= 1'b1;
               end
            end

`ifdef MEM_WRITER_READBACK_EN
            VERIFY: begin
               done      <= 1'b0;
               busy      <= 1'b1;
               wren_reg  <= 1'b0;
               ready_reg <= 1'b0;
               rd_pipe   <= {rd_pipe[0], issue};
               if (issue) begin
                  addr_reg <= next_addr;
                  offset   <= offset + ONE;
               end else begin
                  addr_reg <= addr_reg;
               end
               // q belongs to the address issued two edges ago.
               if (rd_pipe[1]) begin
                  rd_sum <= rd_sum ^ bus.q;
               end else begin
                  rd_sum <= rd_sum;
               end
               // Final read word arrives now: fold it in directly for the verdict.
               if (!issue && rd_pipe == 2'b10) begin
                  mismatch <= ((rd_sum ^ bus.q) != wr_sum);
                  state    <= DONE;
               end else begin
                  state    <= VERIFY;
               end
            end
`endif

            DONE: begin
               done      <= 1'b1;
               busy      <= 1'b0;
               wren_reg  <= 1'b0;
               ready_reg <= 1'b0;
               state     <= IDLE;
            end

            default: begin
               done      <= 1'b0;
               busy      <= 1'b0;
               wren_reg  <= 1'b0;
               ready_reg <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stream_writer.sv
// -----------------------------------------------------------------------------
// tb_mem_stream_writer
// Directed and randomized transfers into mem_stream_writer with a RAM model
// (one registered read stage, so q follows the registered address by two
// edges). Expected writes, cycle positions and the done pulse are computed
// from the transfer parameters and the bench's own valid pattern.
// -----------------------------------------------------------------------------
module tb_mem_stream_writer;
   localparam int DW = 32;
   localparam int AW = 7;
   localparam int DEPTH = 128;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   num_words;
   logic          busy;
   logic          done;
   logic          mismatch;

   mem_stream_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   mem_stream_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .num_words (num_words),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .mismatch  (mismatch)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // edge counter
   always @(posedge clock) cyc <= cyc + 1;

   // RAM model with optional corruption of one address
   logic [DW-1:0] mem [0:DEPTH-1];
   logic          corrupt_en = 1'b0;
   logic [AW-1:0] corrupt_addr = 7'd3;
   always @(posedge clock) begin
      if (bus.wren)
         mem[bus.address] <= (corrupt_en && bus.address == corrupt_addr) ? 32'h0000_DEAD : bus.data;
      bus.q <= mem[bus.address];
   end

   // write / done monitor
   logic [AW-1:0] wa [$];
   logic [DW-1:0] wd [$];
   int            wc [$];
   int            done_total = 0;
   int            done_cyc = 0;
   logic          done_mm = 1'b0;
   always @(negedge clock) begin
      if (bus.wren === 1'b1) begin
         wa.push_back(bus.address);
         wd.push_back(bus.data);
         wc.push_back(cyc);
      end
      if (done === 1'b1) begin
         done_total <= done_total + 1;
         done_cyc   <= cyc;
         done_mm    <= mismatch;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One transfer; called at posedge+2. vmode: 0 valid always, 1 alternate, 2 random.
   task automatic run_xfer(input string tag, input int base, input int num, input int vmode,
                           input bit fixed_words, input bit busy_start, input bit exp_mm);
      int cnt, w0, d0, n, sent, guard, exp_done;
      bit v;
      logic [DW-1:0] words [$];
      int hs [$];
      cnt = (num > DEPTH) ? DEPTH : num;
      for (int i = 0; i < cnt; i++)
         words.push_back(fixed_words ? 32'(i + 1) * 32'h11 : $urandom);
      w0 = wa.size();
      d0 = done_total;
      start = 1'b1;
      base_addr = AW'(base);
      num_words = (AW+1)'(num);
      n = cyc + 1;
      @(posedge clock); #2;
      start = 1'b0;
      sent = 0;
      guard = 0;
      while (sent < cnt && guard < 1000) begin
         case (vmode)
            0: v = 1'b1;
            1: v = (guard % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         bus.in_valid = v;
         bus.in_data = v ? words[sent] : $urandom;
         if (busy_start && guard == 2) begin
            start = 1'b1;
            base_addr = 7'd50;
            num_words = 8'd3;
         end else begin
            start = 1'b0;
         end
         @(negedge clock); #1;
         check($sformatf("%s_ready_%0d", tag, guard), 64'(bus.in_ready), 64'd1);
         if (v) begin
            hs.push_back(cyc + 1);
            sent++;
         end
         @(posedge clock); #2;
         guard++;
      end
      bus.in_valid = 1'b0;
      start = 1'b0;
      check({tag, "_ready_drop"}, 64'(bus.in_ready), 64'd0);
      guard = 0;
      while (done_total == d0 && guard < 500) begin
         @(negedge clock); #1;
         guard++;
      end
      check({tag, "_done_seen"}, 64'(done_total != d0), 64'd1);
      repeat (3) @(posedge clock);
      #2;
      check({tag, "_done_count"}, 64'(done_total - d0), 64'd1);
      check({tag, "_busy_after"}, 64'(busy), 64'd0);
      check({tag, "_nwrites"}, 64'(wa.size() - w0), 64'(cnt));
      for (int i = 0; i < cnt && (w0 + i) < wa.size(); i++) begin
         check($sformatf("%s_addr_%0d", tag, i), 64'(wa[w0 + i]), 64'((base + i) % DEPTH));
         check($sformatf("%s_data_%0d", tag, i), 64'(wd[w0 + i]), 64'(words[i]));
         check($sformatf("%s_wcyc_%0d", tag, i), 64'(wc[w0 + i]), 64'(hs[i]));
         if (vmode == 0)
            check($sformatf("%s_b2b_%0d", tag, i), 64'(hs[i]), 64'(n + 1 + i));
      end
      exp_done = (cnt == 0) ? n + 1 : hs[cnt - 1] + 1;
`ifdef MEM_WRITER_READBACK_EN
      if (cnt > 0) exp_done += cnt + 2;
`endif
      check({tag, "_done_cyc"}, 64'(done_cyc), 64'(exp_done));
      check({tag, "_mismatch"}, 64'(done_mm), 64'(exp_mm));
   endtask

   initial begin
      int w0, d0, guard;
      reset = 1'b1;
      start = 1'b0;
      base_addr = 7'd0;
      num_words = 8'd0;
      bus.in_valid = 1'b0;
      bus.in_data = 32'd0;
      #23;
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_address", 64'(bus.address), 64'd0);
      check("rst_data", 64'(bus.data), 64'd0);
      check("rst_wren", 64'(bus.wren), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_mismatch", 64'(mismatch), 64'd0);
      @(posedge clock); #2;
      reset = 1'b0;
      @(posedge clock); #2;

      run_xfer("b2b", 0, 4, 0, 1'b1, 1'b0, 1'b0);
      run_xfer("gap", 0, 4, 1, 1'b1, 1'b0, 1'b0);
      run_xfer("wrap", 126, 4, 0, 1'b0, 1'b0, 1'b0);
      run_xfer("cap", 0, 200, 0, 1'b0, 1'b0, 1'b0);
      run_xfer("zero", 5, 0, 0, 1'b0, 1'b0, 1'b0);
      run_xfer("busy_start", 10, 6, 0, 1'b0, 1'b1, 1'b0);

      // reset in the middle of a transfer
      w0 = wa.size();
      d0 = done_total;
      start = 1'b1;
      base_addr = 7'd20;
      num_words = 8'd8;
      @(posedge clock); #2;
      start = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = 32'hA5A5_0000;
      guard = 0;
      while (wa.size() < w0 + 2 && guard < 50) begin
         @(negedge clock); #1;
         guard++;
         bus.in_data = 32'hA5A5_0000 + 32'(guard);
      end
      check("rst_mid_two_writes", 64'(wa.size() - w0), 64'd2);
      reset = 1'b1;
      #1;
      check("rst_mid_wren", 64'(bus.wren), 64'd0);
      check("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_mid_busy", 64'(busy), 64'd0);
      @(posedge clock); #2;
      reset = 1'b0;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clock);
      #2;
      check("rst_mid_no_done", 64'(done_total - d0), 64'd0);
      check("rst_mid_no_more_writes", 64'(wa.size() - w0), 64'd2);
      run_xfer("after_rst", 30, 5, 2, 1'b0, 1'b0, 1'b0);

      for (int r = 0; r < 3; r++)
         run_xfer($sformatf("rnd%0d", r), int'($urandom_range(0, DEPTH - 1)),
                  int'($urandom_range(1, 24)), 2, 1'b0, 1'b0, 1'b0);

`ifdef MEM_WRITER_READBACK_EN
      run_xfer("rb_ok", 40, 8, 0, 1'b0, 1'b0, 1'b0);
      corrupt_en = 1'b1;
      run_xfer("rb_bad", 0, 8, 0, 1'b0, 1'b0, 1'b1);
      corrupt_en = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_stream_writer.md
# mem_stream_writer

Write-side companion to the design's single-port M4K operand/result memories: accepts a word stream over a valid/ready handshake and writes it into consecutive RAM addresses starting at a programmable base. It drives the RAM's `address`/`data`/`wren` pins directly, so a multi-word big-integer result (4096 bits = 128 × 32-bit words) can be deposited for later reads by the ROM-style read ports. An optional read-back pass checks the written contents.

## Interface
- `DATA_WIDTH`, 32, RAM word width.
- `ADDR_WIDTH`, 7, RAM address width; depth is 2^ADDR_WIDTH (128).

- `clock`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  single-cycle request to begin a transfer; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first RAM address; captured with `start`.
- `num_words`  in  ADDR_WIDTH+1  words to write (0..2^ADDR_WIDTH); captured with `start`.
- `in_data`  in  DATA_WIDTH  stream word.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  writer accepts a word this cycle.
- `address`  out  ADDR_WIDTH  RAM address.
- `data`  out  DATA_WIDTH  RAM write data.
- `wren`  out  1  RAM write enable.
- `q`  in  DATA_WIDTH  RAM read data (registered RAM output, 2-cycle latency from `address`).
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at end of transfer.
- `mismatch`  out  1  read-back check failed; held until next accepted `start`.

## Operation
- States: IDLE, WRITE, VERIFY (macro only), DONE.
- IDLE: `in_ready`=0, `wren`=0. On `start`: capture `base_addr`, capture count = min(`num_words`, 2^ADDR_WIDTH), clear `mismatch` and checksum; count 0 → DONE, else → WRITE.
- WRITE: `in_ready`=1. Each cycle with `in_valid`&&`in_ready`: register `address` = base+offset, `data` = `in_data`, `wren`=1 for the following cycle; offset++; checksum ^= `in_data`. Cycles without handshake produce `wren`=0. After the count-th handshake `in_ready` drops the next cycle → VERIFY (macro) or DONE.
- Address arithmetic modulo 2^ADDR_WIDTH: base 126, 4 words → 126, 127, 0, 1.
- DONE: `done`=1 for exactly one cycle, → IDLE. `start` during any non-IDLE state is ignored.
- VERIFY: see Configuration.

## Timing
- Reset values: `in_ready`=0, `address`=0, `data`=0, `wren`=0, `busy`=0, `done`=0, `mismatch`=0; state IDLE. Reset mid-transfer aborts immediately (asynchronously drops `wren`); RAM keeps whatever was already written; no `done`.
- `start` at edge n → `busy`=1 and `in_ready`=1 from cycle n+1.
- Handshake at edge k → `wren`/`address`/`data` valid in cycle k+1 (one-cycle registered latency).
- Sustained throughput: one word per cycle; N words with `in_valid` held high: last write in cycle n+N+1, `done` in cycle n+N+2 (no verify).
- `num_words`=0: `done` in cycle n+2, no `wren`.

## Configuration
- `MEM_WRITER_READBACK_EN` defined: after WRITE, VERIFY issues `address` = base..base+count-1 one per cycle with `wren`=0, then waits 2 drain cycles; XORs each `q` (2 cycles after its address) into a read checksum; on completion `mismatch` = (read checksum ≠ write checksum), then DONE. Adds count+2 cycles before `done`.
- Undefined: no VERIFY state; `q` unused; `mismatch` tied 0.

## Test plan
- Reset, then `start` base 0, num 4, words 0x11,0x22,0x33,0x44 back-to-back → `wren` 4 consecutive cycles at addresses 0..3 with those data; `done` one pulse; `busy` low after.
- Same transfer with `in_valid` low every other cycle → writes only on handshake cycles, `wren` gaps match; addresses still 0..3.
- base 126, num 4 → addresses 126,127,0,1; num 200 → exactly 128 writes.
- num 0 → `done` 2 cycles after `start`, no `wren`; `start` pulsed while busy → ignored, count unchanged.
- `reset` asserted after second write → `wren`, `in_ready`, `busy` 0 immediately; no `done`; next `start` runs normally.
- Readback build, RAM model with 2-cycle read latency, 8 words → `mismatch`=0; force address 3 corrupted to 0xDEAD after write → `mismatch`=1 at `done`.
